// File: rtl/ps2_key_receiver_pkg.sv
// Shared frame-state encoding and PS/2 scan-code constants for the key receiver.
package ps2_key_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2State_t;

    localparam logic [7:0] CODE_BREAK  = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_LEFT   = 8'h6B;
    localparam logic [7:0] CODE_RIGHT  = 8'h74;
    localparam logic [7:0] CODE_DOWN   = 8'h72;
    localparam logic [7:0] CODE_ROTATE = 8'h75;

endpackage

// File: rtl/ps2_key_receiver_if.sv
// PS/2 line bundle: raw keyboard pins in, synchronized data and filtered clock edge out.
interface ps2_key_receiver_if;

    logic ps2Clk;
    logic ps2Data;
    logic dataSync;
    logic fallEdge;

    modport master (input ps2Clk, ps2Data, output dataSync, fallEdge);
    modport slave  (output ps2Clk, ps2Data, input dataSync, fallEdge);

endinterface

// File: rtl/ps2_key_receiver_clk_filter.sv
// ps2_clk_filter: 2-FF synchronizers, FILTER_DEPTH glitch filter on the clock, falling-edge pulse.
module ps2_clk_filter #(
    parameter int unsigned FILTER_DEPTH = 4
) (
    input logic clk,
    input logic rst_n,
    ps2_key_receiver_if.master bus
);

    localparam int unsigned CW = $clog2(FILTER_DEPTH + 1);

    logic [1:0]    clkSync;
    logic [1:0]    dataSyncR;
    logic          clkFilt;
    logic [CW-1:0] stableCnt;
    logic          fallEdgeR;

    // A level change is accepted only after FILTER_DEPTH consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkSync   <= '1;
            dataSyncR <= '1;
            clkFilt   <= 1'b1;
            stableCnt <= '0;
            fallEdgeR <= 1'b0;
        end else begin
            clkSync   <= {clkSync[0], bus.ps2Clk};
            dataSyncR <= {dataSyncR[0], bus.ps2Data};
            fallEdgeR <= 1'b0;
            if (clkSync[1] == clkFilt) begin
                stableCnt <= '0;
            end else if (stableCnt == CW'(FILTER_DEPTH - 1)) begin
                clkFilt   <= clkSync[1];
                stableCnt <= '0;
                fallEdgeR <= ~clkSync[1];
            end else begin
                stableCnt <= stableCnt + 1'b1;
            end
        end
    end

    assign bus.dataSync = dataSyncR[1];
    assign bus.fallEdge = fallEdgeR;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: frame decode, F0/E0 prefix tracking, arrow-key hold outputs.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity is wrong.
module ps2_key_receiver
    import ps2_key_receiver_pkg::*;
#(
    parameter int unsigned FILTER_DEPTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_err,
    output logic       moveLeft,
    output logic       moveRight,
    output logic       moveDown,
    output logic       rotate
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_key_receiver_if pins ();

    assign pins.ps2Clk  = ps2_clk;
    assign pins.ps2Data = ps2_data;

    ps2_clk_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_clkFilter (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .bus   (pins)
    );

    ps2State_t     state;
    ps2State_t     stateNext;
    logic [2:0]    bitCnt;
    logic [7:0]    shiftReg;
    logic [TW-1:0] toCnt;
    logic          brkFlag;
    logic          extFlag;
    logic          frameDone;
    logic          badFrame;
    logic          parityOk;

`ifdef PS2_PARITY_CHECK_EN
    logic parityBit;
    assign parityOk = ^{shiftReg, parityBit};
`else
    assign parityOk = 1'b1;
`endif

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) state <= IDLE;
        else             state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        frameDone = 1'b0;
        badFrame  = 1'b0;
        if (pins.fallEdge) begin
            unique case (state)
                IDLE:   if (!pins.dataSync) stateNext = DATA;
                DATA:   if (bitCnt == 3'd7) stateNext = PARITY;
                PARITY: stateNext = STOP;
                STOP: begin
                    stateNext = IDLE;
                    if (pins.dataSync && parityOk) frameDone = 1'b1;
                    else                           badFrame  = 1'b1;
                end
                default: stateNext = IDLE;
            endcase
        end else if (state != IDLE && toCnt == '0) begin
            stateNext = IDLE;
            badFrame  = 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            bitCnt      <= '0;
            shiftReg    <= '0;
            toCnt       <= TW'(TIMEOUT_CYCLES - 1);
            brkFlag     <= 1'b0;
            extFlag     <= 1'b0;
            scan_code   <= '0;
            scan_valid  <= 1'b0;
            is_break    <= 1'b0;
            is_extended <= 1'b0;
            frame_err   <= 1'b0;
            moveLeft    <= 1'b0;
            moveRight   <= 1'b0;
            moveDown    <= 1'b0;
            rotate      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parityBit   <= 1'b0;
`endif
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (pins.fallEdge || state == IDLE) toCnt <= TW'(TIMEOUT_CYCLES - 1);
            else if (toCnt != '0)               toCnt <= toCnt - 1'b1;

            if (pins.fallEdge) begin
                case (state)
                    IDLE: bitCnt <= '0;
                    DATA: begin
                        shiftReg <= {pins.dataSync, shiftReg[7:1]};
                        bitCnt   <= bitCnt + 3'd1;
                    end
`ifdef PS2_PARITY_CHECK_EN
                    PARITY: parityBit <= pins.dataSync;
`endif
                    default: ;
                endcase
            end

            if (badFrame) begin
                frame_err <= 1'b1;
                brkFlag   <= 1'b0;
                extFlag   <= 1'b0;
            end else if (frameDone) begin
                if (shiftReg == CODE_BREAK) begin
                    brkFlag <= 1'b1;
                end else if (shiftReg == CODE_EXT) begin
                    extFlag <= 1'b1;
                end else begin
                    scan_code   <= shiftReg;
                    is_break    <= brkFlag;
                    is_extended <= extFlag;
                    scan_valid  <= 1'b1;
                    brkFlag     <= 1'b0;
                    extFlag     <= 1'b0;
                    // Only E0-prefixed arrow codes drive the hold outputs; make sets, break clears.
                    if (extFlag) begin
                        case (shiftReg)
                            CODE_LEFT:   moveLeft  <= ~brkFlag;
                            CODE_RIGHT:  moveRight <= ~brkFlag;
                            CODE_DOWN:   moveDown  <= ~brkFlag;
                            CODE_ROTATE: rotate    <= ~brkFlag;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench for ps2_key_receiver: directed frames plus random key sequences vs. a key-level model.
`timescale 1ns/1ps
module tb_ps2_key_receiver;

    localparam int HALF = 30;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
        logic [3:0] mv;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] scan_code;
    logic       scan_valid, is_break, is_extended, frame_err;
    logic       moveLeft, moveRight, moveDown, rotate;

    ps2_key_receiver_if kbd ();

    ps2_key_receiver #(.FILTER_DEPTH(4), .TIMEOUT_CYCLES(10000)) dut (
        .CLK100MHZ   (clk),
        .CPU_RESETN  (rst_n),
        .ps2_clk     (kbd.ps2Clk),
        .ps2_data    (kbd.ps2Data),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .is_break    (is_break),
        .is_extended (is_extended),
        .frame_err   (frame_err),
        .moveLeft    (moveLeft),
        .moveRight   (moveRight),
        .moveDown    (moveDown),
        .rotate      (rotate)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   stopFall = 0;
    int   lastLat = 0;
    int   errCnt = 0;
    int   checks = 0;
    int   passCnt = 0;
    int   failCnt = 0;
    ev_t  evQ[$];

    // Key-level reference model state
    logic       mBrk = 1'b0;
    logic       mExt = 1'b0;
    logic [3:0] mMv  = 4'b0000;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (scan_valid) begin
            evQ.push_back('{scan_code, is_break, is_extended, {moveLeft, moveRight, moveDown, rotate}});
            lastLat = cyc - stopFall;
        end
        if (frame_err) errCnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic waitCyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendBit(input logic v, input logic glitch, input logic isStop);
        kbd.ps2Data = v;
        if (glitch) begin
            waitCyc(10);
            kbd.ps2Clk = 1'b0;
            waitCyc(2);
            kbd.ps2Clk = 1'b1;
            waitCyc(HALF - 12);
        end else begin
            waitCyc(HALF);
        end
        kbd.ps2Clk = 1'b0;
        if (isStop) stopFall = cyc;
        waitCyc(HALF);
        kbd.ps2Clk = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic parFlip, input logic stopBit, input int glitchBit);
        logic par;
        par = (~^b) ^ parFlip;
        sendBit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) sendBit(b[i], glitchBit == i, 1'b0);
        sendBit(par, 1'b0, 1'b0);
        sendBit(stopBit, 1'b0, 1'b1);
        kbd.ps2Data = 1'b1;
        waitCyc(HALF);
    endtask

    function automatic int moveIdx(input logic [7:0] c);
        case (c)
            8'h6B:   return 3;
            8'h74:   return 2;
            8'h72:   return 1;
            8'h75:   return 0;
            default: return -1;
        endcase
    endfunction

    task automatic sendByteChecked(input logic [7:0] b, input int glitchBit);
        int   errBefore;
        int   idx;
        int   expN;
        ev_t  expEv;
        ev_t  got;
        errBefore = errCnt;
        expEv = '0;
        sendFrame(b, 1'b0, 1'b1, glitchBit);
        waitCyc(20);
        if (b == 8'hF0) begin
            mBrk = 1'b1;
            expN = 0;
        end else if (b == 8'hE0) begin
            mExt = 1'b1;
            expN = 0;
        end else begin
            idx = moveIdx(b);
            if (mExt && idx >= 0) mMv[idx] = !mBrk;
            expEv = '{b, mBrk, mExt, mMv};
            mBrk = 1'b0;
            mExt = 1'b0;
            expN = 1;
        end
        check($sformatf("evcount_%h", b), evQ.size(), expN);
        check($sformatf("noerr_%h", b), errCnt - errBefore, 0);
        if (evQ.size() > 0) begin
            got = evQ.pop_front();
            check($sformatf("event_%h", b), got, expEv);
        end
        evQ.delete();
    endtask

    initial begin
        int errBefore;
        logic [7:0] codes [7];
        logic [7:0] partial;
        codes = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h1C, 8'h29, 8'h5A};

        kbd.ps2Clk  = 1'b1;
        kbd.ps2Data = 1'b1;
        waitCyc(5);
        check("reset_outputs",
              {scan_code, scan_valid, is_break, is_extended, frame_err, moveLeft, moveRight, moveDown, rotate},
              '0);
        rst_n = 1'b1;
        waitCyc(10);

        // Plain make code and stop-bit to scan_valid latency
        sendByteChecked(8'h1C, -1);
        check("latency_le_8", lastLat <= 8, 1);

        // E0 6B make then E0 F0 6B break
        sendByteChecked(8'hE0, -1);
        sendByteChecked(8'h6B, -1);
        check("moveLeft_set", moveLeft, 1);
        sendByteChecked(8'hE0, -1);
        sendByteChecked(8'hF0, -1);
        sendByteChecked(8'h6B, -1);
        check("moveLeft_clr", moveLeft, 0);

        // Parity bit flipped
        errBefore = errCnt;
        sendFrame(8'h1C, 1'b1, 1'b1, -1);
        waitCyc(20);
`ifdef PS2_PARITY_CHECK_EN
        check("parity_err", errCnt - errBefore, 1);
        check("parity_noev", evQ.size(), 0);
        mBrk = 1'b0;
        mExt = 1'b0;
`else
        check("parity_ign_err", errCnt - errBefore, 0);
        check("parity_ign_ev", evQ.size(), 1);
        if (evQ.size() > 0) check("parity_ign_code", evQ[0].code, 8'h1C);
`endif
        evQ.delete();

        // Bad stop bit after an E0 prefix: error, prefix dropped
        sendByteChecked(8'hE0, -1);
        errBefore = errCnt;
        sendFrame(8'h33, 1'b0, 1'b0, -1);
        waitCyc(20);
        check("stop_err", errCnt - errBefore, 1);
        check("stop_noev", evQ.size(), 0);
        mBrk = 1'b0;
        mExt = 1'b0;
        evQ.delete();

        // Timeout after three data bits, with an E0 pending
        sendByteChecked(8'hE0, -1);
        errBefore = errCnt;
        partial = 8'h11;
        sendBit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) sendBit(partial[i], 1'b0, 1'b0);
        kbd.ps2Data = 1'b1;
        waitCyc(10100);
        check("timeout_err", errCnt - errBefore, 1);
        check("timeout_idle", dut.state, ps2_key_receiver_pkg::IDLE);
        check("timeout_noev", evQ.size(), 0);
        mBrk = 1'b0;
        mExt = 1'b0;
        sendByteChecked(8'h29, -1);

        // Short clock glitch mid-frame
        sendByteChecked(8'h5A, 3);

        // Random key traffic
        for (int n = 0; n < 12; n++) begin
            logic [7:0] c;
            c = codes[$urandom_range(0, 6)];
            if ($urandom_range(0, 1) == 1) sendByteChecked(8'hE0, -1);
            if ($urandom_range(0, 1) == 1) sendByteChecked(8'hF0, -1);
            sendByteChecked(c, -1);
        end
        check("moves_model", {moveLeft, moveRight, moveDown, rotate}, mMv);

        // Reset during bit 4, with moveLeft held beforehand
        sendByteChecked(8'hE0, -1);
        sendByteChecked(8'h6B, -1);
        partial = 8'h75;
        sendBit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sendBit(partial[i], 1'b0, 1'b0);
        kbd.ps2Data = partial[4];
        waitCyc(10);
        rst_n = 1'b0;
        waitCyc(5);
        check("midreset_outputs",
              {scan_code, scan_valid, is_break, is_extended, frame_err, moveLeft, moveRight, moveDown, rotate},
              '0);
        kbd.ps2Clk  = 1'b1;
        kbd.ps2Data = 1'b1;
        waitCyc(3);
        rst_n = 1'b1;
        waitCyc(20);
        evQ.delete();
        mBrk = 1'b0;
        mExt = 1'b0;
        mMv  = 4'b0000;
        sendByteChecked(8'hE0, -1);
        sendByteChecked(8'h75, -1);
        check("rotate_set", rotate, 1);

        $display("%0d/%0d checks passed", passCnt, checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_receiver.md
PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 SHALL have parameter FILTER_DEPTH, default 4, meaning the number of consecutive equal synchronized samples needed to accept a ps2_clk level change.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 10000, meaning the idle CLK100MHZ cycles allowed mid-frame before the frame is aborted (100 us).
REQ-003 SHALL have port CLK100MHZ  input  1  system clock, 100 MHz; sole clock.
REQ-004 SHALL have port CPU_RESETN  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock from the keyboard.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data from the keyboard.
REQ-007 SHALL have port scan_code  output  8  last completed non-prefix code byte.
REQ-008 SHALL have port scan_valid  output  1  one-cycle pulse when scan_code, is_break and is_extended update.
REQ-009 SHALL have port is_break  output  1  the F0 prefix preceded the current scan_code.
REQ-010 SHALL have port is_extended  output  1  the E0 prefix preceded the current scan_code.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on a bad start, parity or stop bit, or on timeout.
REQ-012 SHALL have ports moveLeft, moveRight, moveDown, rotate  output  1 each  high while arrow key E0-6B, E0-74, E0-72 or E0-75 is held.

Function
REQ-013 SHALL pass ps2_clk and ps2_data through 2-FF synchronizers, then apply the FILTER_DEPTH glitch filter to the synchronized ps2_clk.
REQ-014 SHALL detect falling edges of the filtered clock and sample the synchronized ps2_data only at those edges.
REQ-015 SHALL implement the FSM IDLE -> DATA -> PARITY -> STOP -> IDLE; each transition occurs only on a falling edge.
REQ-016 In IDLE, a sampled 0 SHALL move to DATA; a sampled 1 SHALL stay in IDLE with no error.
REQ-017 DATA SHALL shift 8 bits LSB first using a 3-bit counter and move to PARITY after bit 7.
REQ-018 STOP SHALL require a sample of 1; a sample of 0 SHALL pulse frame_err, discard the byte and return to IDLE.
REQ-019 SHALL set the break flag on an accepted byte F0 and the extended flag on E0, without pulsing scan_valid.
REQ-020 On any other accepted byte, SHALL update scan_code, is_break and is_extended and pulse scan_valid in the same cycle, then clear both prefix flags.
REQ-021 scan_valid SHALL assert no more than 8 CLK100MHZ cycles after the ps2_clk pin falls for the stop bit.
REQ-022 On a make of a mapped arrow code (extended, no break), SHALL set the matching move output; on the matching break, SHALL clear it.
REQ-023 Typematic repeats of a held key SHALL leave the move output high without glitching.
REQ-024 Unmapped codes, and mapped codes without E0, SHALL leave the move outputs unchanged.
REQ-025 In any non-IDLE state, TIMEOUT_CYCLES cycles with no falling edge SHALL pulse frame_err, clear the prefix flags and return to IDLE; the counter reloads on every falling edge.
REQ-026 Any frame_err SHALL clear both prefix flags and SHALL NOT change the move outputs.

Reset
REQ-027 CPU_RESETN low SHALL asynchronously force the FSM to IDLE; scan_code to 8'h00; scan_valid, is_break, is_extended, frame_err and all move outputs to 0; and the counters, flags and synchronizers to idle-high, no-edge values.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release, the first valid start bit SHALL begin a new frame.

Configuration
REQ-029 With PS2_PARITY_CHECK_EN defined, a parity mismatch (odd parity over the 8 data bits plus the parity bit) SHALL pulse frame_err and discard the byte.
REQ-030 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be consumed and ignored.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the constants 8'hF0, 8'hE0, 8'h6B, 8'h74, 8'h72 and 8'h75.
REQ-032 The synchronizer plus glitch filter plus edge detector SHALL be one sub-module, ps2_clk_filter, instanced once.

Verification
REQ-033 Frame 1C, parity 0, clean stop -> one scan_valid; scan_code=8'h1C; is_break=0; is_extended=0.
REQ-034 Bytes E0, 6B, then E0, F0, 6B -> moveLeft rises at the 6B scan_valid and falls at the second 6B scan_valid; is_break=1 on the second.
REQ-035 Frame 1C with parity bit 1 -> with PS2_PARITY_CHECK_EN: frame_err pulse, no scan_valid; without it: scan_valid with 8'h1C.
REQ-036 Three data bits, then the clock held high for 10000 cycles -> frame_err pulse, FSM in IDLE; the next frame 8'h29 is decoded correctly.
REQ-037 A 20 ns ps2_clk glitch low mid-frame -> no extra bit sampled; byte 8'h5A is decoded correctly.
REQ-038 CPU_RESETN pulsed low during bit 4 of a frame -> all outputs 0; the next full frame 8'h75 (after E0) sets rotate.
